// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared types, fault codes and PTE/key layout for the TLB refill walker
package tlb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_FILL,
        ST_DONE,
        ST_FAULT,
        ST_FLUSH
    } state_e;

    localparam logic [7:0] FC_NOT_PRESENT = 8'h84;
    localparam logic [7:0] FC_PROT        = 8'h85;
    localparam logic [7:0] FC_BUS_TIMEOUT = 8'h86;

    localparam int PTE_V         = 0;
    localparam int PTE_U         = 1;
    localparam int PTE_FRAME_LSB = 12;
    localparam int PTE_FRAME_W   = 6;

    localparam int PID_W = 12;
    localparam int VPN_W = 20;

    // One 4-byte PTE per VPN; the sum wraps modulo 2^32.
    function automatic logic [31:0] pte_addr(input logic [31:0] base, input logic [31:0] key);
        return base + {10'b0, key[VPN_W-1:0], 2'b00};
    endfunction

endpackage

// File: rtl/tlb_walk_arb.sv
// rtl/tlb_walk_arb.sv - two-port round-robin grant for TLB miss requests
module tlb_walk_arb (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic req0_i,
    input  logic req1_i,
    input  logic take_i,
    output logic gnt_valid_o,
    output logic gnt_port_o
);

    logic last_grant_q, last_grant_d;

    // Contention goes to the port not served last; otherwise the lone requester wins.
    assign gnt_port_o  = (req0_i && req1_i) ? ~last_grant_q : req1_i;
    assign gnt_valid_o = req0_i || req1_i;

    always_comb begin
        last_grant_d = last_grant_q;
        if (take_i) begin
            last_grant_d = gnt_port_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else if (clk_en) begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/tlb_walker.sv
// rtl/tlb_walker.sv - TLB refill controller: arbitrates misses, reads PTEs, fills/flushes the TLB
// Optional READ bus timeout enabled by defining WALK_TIMEOUT_EN.
module tlb_walker
    import tlb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [31:0] ptbr,
    input  logic        miss0_req,
    input  logic [31:0] miss0_key,
    input  logic        miss0_kmode,
    input  logic        miss1_req,
    input  logic [31:0] miss1_key,
    input  logic        miss1_kmode,
    output logic        done0,
    output logic        done1,
    output logic        fault0,
    output logic        fault1,
    output logic [7:0]  fault_code,
    input  logic        flush_req,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        tlb_we,
    output logic [31:0] tlb_key,
    output logic [31:0] tlb_data,
    output logic        tlb_clear,
    output logic        busy
);

    state_e                   state_q, state_d;
    logic [31:0]              key_q;
    logic                     kmode_q;
    logic                     port_q;
    logic [PTE_FRAME_W-1:0]   frame_q;
    logic [7:0]               fc_q;
    logic                     flush_pend_q, flush_pend_d;
    logic                     gnt_valid, gnt_port, take;
    logic                     pte_ok;
    logic                     read_expired;
    logic                     unused_pte;

    assign take   = (state_q == ST_IDLE) && !flush_req && !flush_pend_q && gnt_valid;
    assign pte_ok = mem_rdata[PTE_V] && (kmode_q || mem_rdata[PTE_U]);
    assign unused_pte = ^{mem_rdata[31:PTE_FRAME_LSB+PTE_FRAME_W], mem_rdata[PTE_FRAME_LSB-1:2]};

    tlb_walk_arb u_arb (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .req0_i      (miss0_req),
        .req1_i      (miss1_req),
        .take_i      (take),
        .gnt_valid_o (gnt_valid),
        .gnt_port_o  (gnt_port)
    );

`ifdef WALK_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q;

    assign read_expired = (state_q == ST_READ) && !mem_ready && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (clk_en) begin
            if (take) begin
                to_cnt_q <= '0;
            end else if (state_q == ST_READ) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end
`else
    logic unused_to_cfg;
    assign unused_to_cfg = (TIMEOUT_CYCLES > 0) ^ (TO_W > 0);
    assign read_expired  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_req || flush_pend_q) begin
                    state_d = ST_FLUSH;
                end else if (gnt_valid) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (mem_ready) begin
                    state_d = pte_ok ? ST_FILL : ST_FAULT;
                end else if (read_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FILL:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A flush seen mid-walk is remembered; one seen in FLUSH itself is absorbed.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (state_q == ST_FLUSH) begin
            flush_pend_d = 1'b0;
        end else if (flush_req && state_q != ST_IDLE) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q        <= '0;
            kmode_q      <= 1'b0;
            port_q       <= 1'b0;
            frame_q      <= '0;
            fc_q         <= '0;
            flush_pend_q <= 1'b0;
        end else if (clk_en) begin
            flush_pend_q <= flush_pend_d;
            if (take) begin
                key_q   <= gnt_port ? miss1_key : miss0_key;
                kmode_q <= gnt_port ? miss1_kmode : miss0_kmode;
                port_q  <= gnt_port;
            end
            if (state_q == ST_READ && mem_ready) begin
                frame_q <= mem_rdata[PTE_FRAME_LSB +: PTE_FRAME_W];
                fc_q    <= mem_rdata[PTE_V] ? FC_PROT : FC_NOT_PRESENT;
            end else if (read_expired) begin
                fc_q    <= FC_BUS_TIMEOUT;
            end
        end
    end

    // Pulses are gated by the live request so a withdrawn requester sees nothing.
    always_comb begin
        mem_req    = 1'b0;
        mem_addr   = '0;
        tlb_we     = 1'b0;
        tlb_key    = '0;
        tlb_data   = '0;
        tlb_clear  = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        fault0     = 1'b0;
        fault1     = 1'b0;
        fault_code = '0;
        unique case (state_q)
            ST_READ: begin
                mem_req  = 1'b1;
                mem_addr = pte_addr(ptbr, key_q);
            end
            ST_FILL: begin
                tlb_we   = 1'b1;
                tlb_key  = key_q;
                tlb_data = {{(32-PTE_FRAME_W){1'b0}}, frame_q};
            end
            ST_DONE: begin
                done0 = !port_q && miss0_req;
                done1 = port_q && miss1_req;
            end
            ST_FAULT: begin
                fault0     = !port_q && miss0_req;
                fault1     = port_q && miss1_req;
                fault_code = (fault0 || fault1) ? fc_q : 8'h00;
            end
            ST_FLUSH: tlb_clear = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE) || flush_pend_q;

endmodule

// File: tb/tb_tlb_walker.sv
// tb/tb_tlb_walker.sv - directed vector bench for tlb_walker
module tb_tlb_walker;

    logic        clk = 1'b0;
    logic        rst, clk_en;
    logic [31:0] ptbr;
    logic        miss0_req, miss0_kmode, miss1_req, miss1_kmode;
    logic [31:0] miss0_key, miss1_key;
    logic        done0, done1, fault0, fault1;
    logic [7:0]  fault_code;
    logic        flush_req, mem_req, mem_ready;
    logic [31:0] mem_addr, mem_rdata;
    logic        tlb_we, tlb_clear, busy;
    logic [31:0] tlb_key, tlb_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tlb_walker #(.TIMEOUT_CYCLES(8), .TO_W(10)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .ptbr(ptbr),
        .miss0_req(miss0_req), .miss0_key(miss0_key), .miss0_kmode(miss0_kmode),
        .miss1_req(miss1_req), .miss1_key(miss1_key), .miss1_kmode(miss1_kmode),
        .done0(done0), .done1(done1), .fault0(fault0), .fault1(fault1),
        .fault_code(fault_code), .flush_req(flush_req),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .tlb_we(tlb_we), .tlb_key(tlb_key), .tlb_data(tlb_data),
        .tlb_clear(tlb_clear), .busy(busy)
    );

    typedef struct {
        logic        port;
        logic [31:0] key;
        logic        kmode;
        logic [31:0] ptbr;
        logic [31:0] pte;
        logic [31:0] exp_addr;
        logic        exp_fill;
        logic [31:0] exp_data;
        logic [7:0]  exp_fc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_mem_req(input int budget);
        int i = 0;
        @(negedge clk);
        while (!mem_req && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("mem_req_seen", {31'b0, mem_req}, 32'd1);
    endtask

    task automatic set_req(input logic port, input logic [31:0] key, input logic kmode);
        if (port) begin
            miss1_req = 1'b1; miss1_key = key; miss1_kmode = kmode;
        end else begin
            miss0_req = 1'b1; miss0_key = key; miss0_kmode = kmode;
        end
    endtask

    // Caller has raised the request; serves one walk and drops the request at its end.
    task automatic serve(input logic port, input logic [31:0] key, input logic [31:0] addr,
                         input logic [31:0] pte, input logic fill, input logic [31:0] data,
                         input logic [7:0] fc);
        wait_mem_req(6);
        chk("mem_addr", mem_addr, addr);
        mem_ready = 1'b1; mem_rdata = pte;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("tlb_we", {31'b0, tlb_we}, {31'b0, fill});
        if (fill) begin
            chk("tlb_key", tlb_key, key);
            chk("tlb_data", tlb_data, data);
            @(negedge clk);
            chk("done", {30'b0, done1, done0}, port ? 32'd2 : 32'd1);
        end else begin
            chk("fault", {30'b0, fault1, fault0}, port ? 32'd2 : 32'd1);
            chk("fault_code", {24'b0, fault_code}, {24'b0, fc});
        end
        if (port) miss1_req = 1'b0; else miss0_req = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int clr_cnt;
        rst = 1'b1; clk_en = 1'b1; ptbr = '0;
        miss0_req = 0; miss0_key = '0; miss0_kmode = 0;
        miss1_req = 0; miss1_key = '0; miss1_kmode = 0;
        flush_req = 0; mem_ready = 0; mem_rdata = '0;

        vecs[0] = '{1'b1, 32'h0050_0003, 1'b0, 32'h0000_1000, 32'h0002_F003, 32'h0000_100C, 1'b1, 32'h2F, 8'h00};
        vecs[1] = '{1'b1, 32'h0050_0003, 1'b0, 32'h0000_1000, 32'h0000_1001, 32'h0000_100C, 1'b0, 32'h00, 8'h85};
        vecs[2] = '{1'b1, 32'h0050_0003, 1'b1, 32'h0000_1000, 32'h0000_1001, 32'h0000_100C, 1'b1, 32'h01, 8'h00};
        vecs[3] = '{1'b0, 32'h123A_BCDE, 1'b1, 32'h8000_0000, 32'h0000_0000, 32'h802A_F378, 1'b0, 32'h00, 8'h84};
        vecs[4] = '{1'b0, 32'h0000_0010, 1'b0, 32'hFFFF_FFF0, 32'h0003_F003, 32'h0000_0030, 1'b1, 32'h3F, 8'h00};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'hFFFF_FFFE, 32'h003F_FFFC, 1'b0, 32'h00, 8'h84};
        vecs[6] = '{1'b0, 32'h0000_0001, 1'b0, 32'h0000_0100, 32'h0001_5003, 32'h0000_0104, 1'b1, 32'h15, 8'h00};

        #1;
        chk("rst_outputs", {mem_req, tlb_we, tlb_clear, busy, done0, done1, fault0, fault1, fault_code},
            32'd0);
        @(negedge clk); rst = 1'b0;

        // Both ports at once after reset: port 1 first, then port 0.
        ptbr = 32'h0;
        set_req(1'b1, 32'h0000_0005, 1'b0);
        set_req(1'b0, 32'h0000_0002, 1'b0);
        serve(1'b1, 32'h0000_0005, 32'h0000_0014, 32'h0000_A003, 1'b1, 32'h0A, 8'h00);
        miss0_req = 1'b1;
        serve(1'b0, 32'h0000_0002, 32'h0000_0008, 32'h0000_B003, 1'b1, 32'h0B, 8'h00);

        for (int i = 0; i < 7; i++) begin
            ptbr = vecs[i].ptbr;
            set_req(vecs[i].port, vecs[i].key, vecs[i].kmode);
            serve(vecs[i].port, vecs[i].key, vecs[i].exp_addr, vecs[i].pte,
                  vecs[i].exp_fill, vecs[i].exp_data, vecs[i].exp_fc);
        end

        // Flush during READ: walk finishes, then exactly one clear, busy held throughout.
        ptbr = 32'h1000;
        set_req(1'b1, 32'h0000_0001, 1'b1);
        wait_mem_req(6);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        chk("flush_busy_read", {31'b0, busy}, 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h0000_7001;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("flush_we", {31'b0, tlb_we}, 32'd1);
        chk("flush_clr_early", {31'b0, tlb_clear}, 32'd0);
        @(negedge clk);
        chk("flush_done1", {31'b0, done1}, 32'd1);
        miss1_req = 1'b0;
        clr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clr_cnt == 0) chk("flush_busy", {31'b0, busy}, 32'd1);
            if (tlb_clear) clr_cnt++;
        end
        chk("flush_clear_count", clr_cnt, 1);
        chk("flush_busy_end", {31'b0, busy}, 32'd0);

        // flush_req in the FLUSH cycle is absorbed.
        flush_req = 1'b1;
        @(negedge clk);
        chk("absorb_clear1", {31'b0, tlb_clear}, 32'd1);
        @(negedge clk);
        flush_req = 1'b0;
        chk("absorb_no_second", {30'b0, tlb_clear, busy}, 32'd0);

        // Requester withdraws mid-walk: fill happens, done suppressed.
        set_req(1'b0, 32'h0000_0003, 1'b1);
        wait_mem_req(6);
        miss0_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0000_9001;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("drop_we", {31'b0, tlb_we}, 32'd1);
        @(negedge clk);
        chk("drop_no_done", {30'b0, done1, done0}, 32'd0);
        @(negedge clk);

        // clk_en low freezes READ.
        set_req(1'b1, 32'h0000_0004, 1'b1);
        wait_mem_req(6);
        clk_en = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0000_5001;
        @(negedge clk); @(negedge clk);
        chk("clken_hold", {30'b0, mem_req, tlb_we}, 32'd2);
        clk_en = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("clken_resume_we", {31'b0, tlb_we}, 32'd1);
        miss1_req = 1'b0;
        @(negedge clk); @(negedge clk);

        // Async reset mid-READ, then a normal walk.
        ptbr = 32'h2000;
        set_req(1'b1, 32'h0000_0002, 1'b0);
        wait_mem_req(6);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_walk", {29'b0, mem_req, busy, tlb_we}, 32'd0);
        @(negedge clk); rst = 1'b0;
        serve(1'b1, 32'h0000_0002, 32'h0000_2008, 32'h0000_C003, 1'b1, 32'h0C, 8'h00);

`ifdef WALK_TIMEOUT_EN
        set_req(1'b1, 32'h0000_0006, 1'b0);
        wait_mem_req(6);
        for (int i = 1; i < 8; i++) @(negedge clk);
        chk("to_last_read", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        chk("to_fault", {31'b0, fault1}, 32'd1);
        chk("to_code", {24'b0, fault_code}, 32'h86);
        chk("to_mem_req_drop", {31'b0, mem_req}, 32'd0);
        miss1_req = 1'b0;
        @(negedge clk);
        set_req(1'b1, 32'h0000_0006, 1'b0);
        wait_mem_req(6);
        for (int i = 1; i < 8; i++) @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h0000_D003;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("to_late_fill", {31'b0, tlb_we}, 32'd1);
        chk("to_late_data", tlb_data, 32'h0D);
        miss1_req = 1'b0;
        @(negedge clk); @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/tlb_walker.md
Name: tlb_walker

Overview:
- Hardware TLB refill controller: arbitrates TLB-miss requests from the fetch port (port 0) and the memory port (port 1).
- Reads the page-table entry (PTE) from memory, then writes the translation into the 8-entry TLB through its `we`/`read_addr`/`write_data` port.
- Sequences TLB `clear` (flush) requests so that a flush never overlaps a fill.
- Sits between the pipeline's miss detection, the memory arbiter and the TLB.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles waiting for `mem_ready` (used only with WALK_TIMEOUT_EN).
- TO_W, 10: width of the timeout counter; requires TIMEOUT_CYCLES ≤ 2^TO_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  global clock enable; all state frozen when low
- ptbr  in  32  page-table base address (byte)
- miss0_req  in  1  fetch-port miss, held until done0/fault0
- miss0_key  in  32  {pid[11:0], vpn[19:0]}
- miss0_kmode  in  1  requester privilege
- miss1_req  in  1  memory-port miss, held until done1/fault1
- miss1_key  in  32  {pid, vpn}
- miss1_kmode  in  1  requester privilege
- done0, done1  out  1  one-cycle pulse: TLB filled for that port
- fault0, fault1  out  1  one-cycle pulse: page fault for that port
- fault_code  out  8  valid while a faultN pulse is high
- flush_req  in  1  pulse: request TLB clear
- mem_req  out  1  PTE read request
- mem_addr  out  32  PTE address
- mem_ready  in  1  read data valid this cycle
- mem_rdata  in  32  PTE
- tlb_we  out  1  TLB write strobe
- tlb_key  out  32  TLB key (drives TLB read_addr)
- tlb_data  out  32  {26'b0, frame[5:0]}
- tlb_clear  out  1  TLB clear strobe
- busy  out  1  state ≠ IDLE, or a flush is pending

Behaviour:
- Reset: state = IDLE, last_grant = 0, flush_pend = 0; every output is 0.
- clk_en = 0: no state, counter or register changes; outputs hold their current values.
- States: IDLE, READ, FILL, DONE, FAULT, FLUSH.
- IDLE, in priority order:
  - flush_req or flush_pend → FLUSH.
  - Else, if any missN_req: grant a port. With both pending, grant the port ≠ last_grant (round-robin). Latch key, kmode and port; set last_grant; go to READ.
- READ:
  - mem_req = 1; mem_addr = ptbr + {10'b0, key[19:0], 2'b00}, truncated mod 2^32.
  - mem_req held until the cycle mem_ready = 1; that PTE is latched.
  - Next state: FILL if PTE valid and permitted, else FAULT.
- PTE format: bit0 V, bit1 U, bits[17:12] frame.
  - Permitted = V && (kmode || U).
  - !V → fault_code = FC_NOT_PRESENT (8'h84).
  - V && !kmode && !U → fault_code = FC_PROT (8'h85).
- FILL: one cycle. tlb_we = 1, tlb_key = latched key, tlb_data = {26'b0, pte[17:12]}. → DONE.
- DONE: doneN pulses for the granted port → IDLE.
- FAULT: faultN pulses with fault_code → IDLE. No TLB write occurs.
- Latency: with grant at cycle T and mem_ready at T+1, tlb_we is at T+2 and done at T+3.
- Requester drop: if the granted missN_req deasserts before DONE/FAULT, the walk and fill still complete, but the done/fault pulse is suppressed.
- Flush vs. walk:
  - flush_req arriving during a walk sets flush_pend. The flush executes after returning to IDLE, ahead of any waiting miss.
  - FLUSH: tlb_clear = 1 for one cycle; clear flush_pend → IDLE.
  - flush_req arriving in the FLUSH cycle itself is absorbed (no second clear).
- Fill key precondition: a walk never writes a key already valid in the TLB, because misses are only raised on lookup failure.
- Asynchronous reset mid-walk: mem_req drops immediately and the PTE read is abandoned. The memory arbiter must tolerate a withdrawn request.
- busy = (state ≠ IDLE) || flush_pend.

Optional Feature:
- Macro WALK_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to READ and increments each enabled READ cycle.
  - When it reaches TIMEOUT_CYCLES-1 without mem_ready: drop mem_req, go to FAULT with FC_BUS_TIMEOUT (8'h86).
  - mem_ready in that same cycle wins (normal completion).
- Undefined: no counter exists; READ waits indefinitely.

Decomposition:
- Package tlb_pkg:
  - state enum.
  - FC_NOT_PRESENT, FC_PROT, FC_BUS_TIMEOUT.
  - PTE bit positions (PTE_V = 0, PTE_U = 1, PTE_FRAME_LSB = 12, PTE_FRAME_W = 6).
  - Key field widths (PID_W = 12, VPN_W = 20).
- One sub-module: tlb_walk_arb, the 2-port round-robin grant with last_grant register. Everything else stays in tlb_walker.

Test Plan:
- Single miss: miss1_req with key 0x00500003, ptbr = 0x1000 → mem_addr = 0x100C. PTE 0x0002F003 → tlb_we with tlb_data = 0x2F, then done1 one cycle later.
- Simultaneous miss0_req and miss1_req after reset (last_grant = 0) → port 1 serviced first, then port 0, each with its own key, with two tlb_we pulses.
- User miss, PTE = 0x00001001 (V = 1, U = 0), kmode = 0 → fault1 with fault_code 0x85 and no tlb_we. Same PTE with kmode = 1 → fill.
- flush_req pulsed during READ → walk completes (tlb_we, done), then tlb_clear for exactly one cycle; busy stays high throughout.
- rst asserted while mem_req = 1 → mem_req, busy and all strobes go 0 in the same cycle. After release, a new miss walks normally.
- WALK_TIMEOUT_EN with TIMEOUT_CYCLES = 8, mem_ready held 0 → fault with 0x86 after 8 READ cycles. A second run with mem_ready on cycle 8 → normal fill.
